voice_mixer: RTL and testbench

- Downstream of the per-voice output stage.
- Takes the signed `dout` samples of NUM_VOICES voices and applies a 4-bit per-voice gain and a 4-bit master volume.
- Sums the voices with a single time-multiplexed multiply-accumulate, one voice per main_clk cycle.
- Delivers one saturated signed sample per sample_clk period to the DAC/PDM output stage.

---
 rtl/voice_mixer.sv | 159 +++++++++++++++
 tb/tb_voice_mixer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/voice_mixer.sv
// Voice mixer: snapshots NUM_VOICES signed samples on a sample_clk edge, runs a
// serial gain MAC (one voice per cycle), applies master volume and saturates.
module voice_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int DATA_BITS  = 12,
  parameter int GAIN_BITS  = 4,
  parameter int SHIFT      = 8
) (
  input  logic                            main_clk,
  input  logic                            rst,
  input  logic                            sample_clk,
  input  logic [NUM_VOICES*DATA_BITS-1:0] voice_in,
  input  logic [NUM_VOICES*GAIN_BITS-1:0] voice_gain,
  input  logic [GAIN_BITS-1:0]            master_vol,
  output logic signed [DATA_BITS-1:0]     dout,
  output logic                            dout_valid,
  output logic                            clipped,
  output logic                            busy,
  output logic                            overrun
);

  localparam int ACC_W  = DATA_BITS + GAIN_BITS + $clog2(NUM_VOICES) + 1;
  localparam int PROD_W = ACC_W + GAIN_BITS;
  localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((2 ** (DATA_BITS - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUTPUT} state_t;

  typedef struct packed {
    logic [NUM_VOICES-1:0][DATA_BITS-1:0] v;
    logic [NUM_VOICES-1:0][GAIN_BITS-1:0] g;
    logic [GAIN_BITS-1:0]                 m;
  } snap_t;

  state_t                     state_q, state_d;
  snap_t                      snap_q, snap_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic signed [DATA_BITS-1:0] sat_q, sat_d;
  logic                       sat_flag_q, sat_flag_d;
  logic signed [DATA_BITS-1:0] dout_q, dout_d;
  logic                       dout_valid_q, dout_valid_d;
  logic                       clipped_q, clipped_d;
  logic                       busy_q, busy_d;
  logic                       overrun_q, overrun_d;
  logic                       sclk_q, sclk_d;

  logic                        trigger;
  logic signed [DATA_BITS-1:0] v_sel;
  logic signed [ACC_W-1:0]     v_ext, g_ext, term;
  logic signed [PROD_W-1:0]    acc_ext, mvol_ext, prod;

  // MAC and scale datapath; all operands widened first so nothing can overflow
  always_comb begin
    v_sel    = snap_q.v[idx_q];
    v_ext    = ACC_W'(v_sel);
    g_ext    = ACC_W'({1'b0, snap_q.g[idx_q]});
    term     = v_ext * g_ext;
    acc_ext  = PROD_W'(acc_q);
    mvol_ext = PROD_W'({1'b0, snap_q.m});
    prod     = (acc_ext * mvol_ext) >>> SHIFT;
  end

  always_comb begin
    trigger      = sample_clk & ~sclk_q;
    sclk_d       = sample_clk;
    state_d      = state_q;
    snap_d       = snap_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    sat_d        = sat_q;
    sat_flag_d   = sat_flag_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    clipped_d    = clipped_q;
    overrun_d    = overrun_q;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          snap_d.v = voice_in;
          snap_d.g = voice_gain;
          snap_d.m = master_vol;
          acc_d    = '0;
          idx_d    = '0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + term;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) state_d = SCALE;
      end
      SCALE: begin
        if (prod > SAT_MAX) begin
          sat_d      = DATA_BITS'(SAT_MAX);
          sat_flag_d = 1'b1;
        end else if (prod < SAT_MIN) begin
          sat_d      = DATA_BITS'(SAT_MIN);
          sat_flag_d = 1'b1;
        end else begin
          sat_d      = DATA_BITS'(prod);
          sat_flag_d = 1'b0;
        end
        state_d = OUTPUT;
      end
      OUTPUT: begin
        dout_d       = sat_q;
        clipped_d    = sat_flag_q;
        dout_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A trigger that lands mid-mix is dropped; only the sticky flag records it
    if (trigger && (state_q != IDLE)) overrun_d = 1'b1;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge main_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      snap_q       <= '0;
      acc_q        <= '0;
      idx_q        <= '0;
      sat_q        <= '0;
      sat_flag_q   <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      clipped_q    <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      sclk_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      sat_q        <= sat_d;
      sat_flag_q   <= sat_flag_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      clipped_q    <= clipped_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      sclk_q       <= sclk_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign clipped    = clipped_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: per-cycle compare against a cycle-count
// model plus literal expectations for each scenario.
module tb_voice_mixer;
  localparam int N = 4;
  localparam int D = 12;
  localparam int G = 4;
  localparam int LAT = N + 2;

  logic main_clk = 1'b0;
  logic rst = 1'b0;
  logic sample_clk = 1'b0;
  logic [N*D-1:0] voice_in = '0;
  logic [N*G-1:0] voice_gain = '0;
  logic [G-1:0]   master_vol = '0;
  logic signed [D-1:0] dout;
  logic dout_valid, clipped, busy, overrun;

  voice_mixer #(.NUM_VOICES(N), .DATA_BITS(D), .GAIN_BITS(G), .SHIFT(8)) dut (
    .main_clk(main_clk), .rst(rst), .sample_clk(sample_clk),
    .voice_in(voice_in), .voice_gain(voice_gain), .master_vol(master_vol),
    .dout(dout), .dout_valid(dout_valid), .clipped(clipped),
    .busy(busy), .overrun(overrun));

  always #5 main_clk = ~main_clk;

  int checks = 0;
  int errors = 0;
  int nvalid = 0;
  int last_dout = 0;
  int last_clip = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Mix result from plain integer arithmetic: sum, scale, floor-divide, clamp.
  function automatic void mix(input logic [N*D-1:0] vi, input logic [N*G-1:0] gi,
                              input logic [G-1:0] m, output int val, output int clip);
    longint s = 0;
    longint p, q, sv, sg, sm;
    for (int i = 0; i < N; i++) begin
      sv = longint'($signed(vi[i*D +: D]));
      sg = longint'(gi[i*G +: G]);
      s += sv * sg;
    end
    sm = longint'(m);
    p = s * sm;
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q -= 1;
    clip = 0;
    if (q > 2047) begin q = 2047; clip = 1; end
    else if (q < -2048) begin q = -2048; clip = 1; end
    val = int'(q);
  endfunction

  // Model: tracks age of the in-flight mix in cycles since its trigger edge
  int  m_age = -1;
  int  m_pend_v = 0, m_pend_c = 0;
  int  m_dout = 0, m_clip = 0;
  bit  m_valid = 0, m_ovr = 0, m_sprev = 0;

  always @(posedge main_clk or posedge rst) begin
    if (rst) begin
      m_age = -1; m_dout = 0; m_clip = 0; m_valid = 0; m_ovr = 0; m_sprev = 0;
    end else begin
      bit was_busy, trig;
      was_busy = (m_age != -1);
      trig = sample_clk && !m_sprev;
      m_sprev = sample_clk;
      m_valid = 0;
      if (was_busy) begin
        m_age++;
        if (m_age == LAT) begin
          m_dout = m_pend_v; m_clip = m_pend_c; m_valid = 1; m_age = -1;
        end
      end
      if (trig) begin
        if (was_busy) m_ovr = 1;
        else begin
          mix(voice_in, voice_gain, master_vol, m_pend_v, m_pend_c);
          m_age = 0;
        end
      end
    end
  end

  always @(negedge main_clk) begin
    chk("dout", int'(dout), m_dout);
    chk("clipped", int'(clipped), m_clip);
    chk("dout_valid", int'(dout_valid), int'(m_valid));
    chk("busy", int'(busy), int'(m_age != -1));
    chk("overrun", int'(overrun), int'(m_ovr));
    if (dout_valid) begin
      nvalid++;
      last_dout = int'(dout);
      last_clip = int'(clipped);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge main_clk);
    #2;
  endtask

  task automatic set_in(input int v0, v1, v2, v3, input int g0, g1, g2, g3, input int m);
    voice_in   = {D'(v3), D'(v2), D'(v1), D'(v0)};
    voice_gain = {G'(g3), G'(g2), G'(g1), G'(g0)};
    master_vol = G'(m);
  endtask

  // Raise sample_clk, measure edges from trigger to dout_valid, check the result
  task automatic run_mix(input string name, input int exp_v, input int exp_c);
    int lat = -1;
    int n0 = nvalid;
    sample_clk = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge main_clk); #1;
      if (dout_valid && lat < 0) lat = k;
    end
    #1;
    sample_clk = 1'b0;
    tick(1);
    chk({name, "_latency"}, lat, LAT);
    chk({name, "_pulses"}, nvalid - n0, 1);
    chk({name, "_dout"}, last_dout, exp_v);
    chk({name, "_clip"}, last_clip, exp_c);
  endtask

  initial begin
    int n0;
    #1 rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(5);
    chk("rst_dout", int'(dout), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovr", int'(overrun), 0);
    chk("rst_pulses", nvalid, 0);

    set_in(1000, 0, 0, 0, 15, 0, 0, 0, 15);
    run_mix("single", 878, 0);
    set_in(-1000, 0, 0, 0, 15, 0, 0, 0, 15);
    run_mix("negfloor", -879, 0);
    set_in(2047, 2047, 2047, 2047, 15, 15, 15, 15, 15);
    run_mix("satpos", 2047, 1);
    set_in(-2048, -2048, -2048, -2048, 15, 15, 15, 15, 15);
    run_mix("satneg", -2048, 1);
    set_in(-2048, -2048, -2048, -2048, 15, 15, 15, 15, 0);
    run_mix("mvol0", 0, 0);
    set_in(2047, -2048, 2047, 1, 0, 0, 0, 0, 15);
    run_mix("gain0", 0, 0);
    set_in(100, 200, -300, 400, 1, 2, 3, 4, 8);
    run_mix("mixed", 37, 0);

    // Snapshot: inputs change during ACCUM must not affect the result
    set_in(500, 0, 0, 0, 15, 0, 0, 0, 15);
    sample_clk = 1'b1;
    tick(2);
    set_in(-1500, 900, 7, 3, 1, 15, 15, 15, 3);
    tick(10);
    sample_clk = 1'b0;
    tick(1);
    chk("snapshot_dout", last_dout, 439);

    // Overrun: second rising edge sampled 3 cycles after the first
    set_in(1000, 0, 0, 0, 15, 0, 0, 0, 15);
    n0 = nvalid;
    sample_clk = 1'b1;
    tick(1);
    sample_clk = 1'b0;
    tick(2);
    sample_clk = 1'b1;
    tick(12);
    sample_clk = 1'b0;
    tick(2);
    chk("ovr_flag", int'(overrun), 1);
    chk("ovr_pulses", nvalid - n0, 1);
    chk("ovr_dout", last_dout, 878);

    // Mid-mix reset two cycles after the trigger edge
    set_in(-700, 0, 0, 0, 15, 0, 0, 0, 15);
    n0 = nvalid;
    sample_clk = 1'b1;
    tick(2);
    rst = 1'b1;
    #1;
    chk("mrst_dout", int'(dout), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_ovr", int'(overrun), 0);
    sample_clk = 1'b0;
    tick(10);
    rst = 1'b0;
    tick(2);
    chk("mrst_pulses", nvalid - n0, 0);
    set_in(100, 200, -300, 400, 1, 2, 3, 4, 8);
    run_mix("after_rst", 37, 0);
    chk("after_rst_ovr", int'(overrun), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
